// File: rtl/mem_store_fwd_queue.sv
// Store queue with zero-latency head issue and youngest-match store-to-load forwarding.
// Pointers wrap naturally because DEPTH is a power of two.
module mem_store_fwd_queue #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 16,
  parameter int DEPTH      = 128,
  parameter int EDGE_WRITE = 1,
  parameter int AFULL_LVL  = DEPTH - 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic                       rd_ready,
  output logic [DATA_W-1:0]          rd_data,
  output logic [ADDR_W-1:0]          rd_addr,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     count,
  input  logic [ADDR_W-1:0]          lk_addr,
  output logic                       lk_hit,
  output logic [DATA_W-1:0]          lk_data,
  output logic                       drop_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addrMem [DEPTH];
  logic [DATA_W-1:0] dataMem [DEPTH];

  logic             wrEn_q;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             dropErr_q, dropErr_d;

  logic pushReq;
  logic pop;
  logic push;
  logic drop;

  assign full        = (count_q == CNT_W'(DEPTH));
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= CNT_W'(AFULL_LVL));
  assign count       = count_q;
  assign drop_err    = dropErr_q;

  assign pushReq  = (EDGE_WRITE != 0) ? (wr_en && !wrEn_q) : wr_en;
  assign pop      = rd_ready && !empty;
  assign push     = pushReq && (!full || pop);
  assign drop     = pushReq && full && !pop;
  assign rd_valid = pop;
  assign rd_data  = dataMem[rdPtr_q];
  assign rd_addr  = addrMem[rdPtr_q];

  always_comb begin
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    count_d   = count_q;
    dropErr_d = dropErr_q | drop;
    if (push) wrPtr_d = wrPtr_q + 1'b1;
    if (pop)  rdPtr_d = rdPtr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrEn_q    <= 1'b0;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      dropErr_q <= 1'b0;
    end else begin
      wrEn_q    <= wr_en;
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      dropErr_q <= dropErr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addrMem[wrPtr_q] <= wr_addr;
      dataMem[wrPtr_q] <= wr_data;
    end
  end

  // Walk from oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    logic [PTR_W-1:0] idx;
    lk_hit  = 1'b0;
    lk_data = '0;
    idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rdPtr_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (addrMem[idx] == lk_addr)) begin
        lk_hit  = 1'b1;
        lk_data = dataMem[idx];
      end
    end
  end

endmodule

// File: doc/mem_store_fwd_queue.md
MEM_STORE_FWD_QUEUE -- requirements
Module: mem_store_fwd_queue

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning):
REQ-002 DATA_W, 8, store data width in bits.
REQ-003 ADDR_W, 16, store address width in bits.
REQ-004 DEPTH, 128, entry count; power of two, at least 2.
REQ-005 EDGE_WRITE, 1, 1 = push on rising edge of wr_en, 0 = push on every cycle wr_en is high.
REQ-006 AFULL_LVL, DEPTH-4, occupancy at or above which almost_full asserts.
REQ-007 Ports SHALL be as follows (name, direction, width, meaning). One clock; reset is asynchronous and active-high:
REQ-008 clk, in, 1, sole clock, rising edge.
REQ-009 rst, in, 1, asynchronous active-high reset.
REQ-010 wr_en, in, 1, store request strobe.
REQ-011 wr_data, in, DATA_W, store data.
REQ-012 wr_addr, in, ADDR_W, store address.
REQ-013 rd_ready, in, 1, memory port can accept the head store this cycle.
REQ-014 rd_data, out, DATA_W, head entry data.
REQ-015 rd_addr, out, ADDR_W, head entry address.
REQ-016 rd_valid, out, 1, head store issued this cycle.
REQ-017 full, out, 1, occupancy equals DEPTH.
REQ-018 empty, out, 1, occupancy equals 0.
REQ-019 almost_full, out, 1, occupancy at or above AFULL_LVL.
REQ-020 count, out, clog2(DEPTH)+1, current occupancy.
REQ-021 lk_addr, in, ADDR_W, forwarding lookup address.
REQ-022 lk_hit, out, 1, a queued entry matches lk_addr.
REQ-023 lk_data, out, DATA_W, data of the youngest matching entry.
REQ-024 drop_err, out, 1, sticky flag: a push was discarded.

Function
REQ-025 push_req SHALL be (wr_en && !wr_en_q) when EDGE_WRITE=1, and wr_en when EDGE_WRITE=0; wr_en_q is wr_en registered on clk.
REQ-026 pop SHALL be rd_ready && !empty.
REQ-027 push SHALL be push_req && (!full || pop), so a push into a full queue is accepted when a pop occurs in the same cycle.
REQ-028 On push, wr_data and wr_addr SHALL be written at the write pointer, which then advances by 1 modulo DEPTH.
REQ-029 On pop, the read pointer SHALL advance by 1 modulo DEPTH.
REQ-030 count SHALL change by +1 on push only, -1 on pop only, and 0 when push and pop occur together or neither occurs.
REQ-031 rd_data and rd_addr SHALL combinationally present the entry at the read pointer; their value is don't-care while empty.
REQ-032 rd_valid SHALL equal pop; the consumer samples the store in the same cycle, with zero latency.
REQ-033 A pushed entry SHALL first be visible on rd_* and to lookup in the cycle after its push.
REQ-034 full, empty, almost_full and count SHALL be registered-state derived and SHALL update in the cycle after the push or pop.
REQ-035 lk_hit SHALL be combinational: 1 if any occupied entry's address equals lk_addr, counting the head even when it is popping this cycle.
REQ-036 lk_data SHALL come from the matching entry closest to the write pointer, i.e. the youngest match; it is don't-care when lk_hit=0.
REQ-037 Occupancy SHALL be judged by the read/write pointers plus count, not by stale array contents; wrapped-around slots are never reported.
REQ-038 If push_req && full && !pop, the push SHALL be discarded, state unchanged, and drop_err set to 1 until reset.

Reset
REQ-039 Asserting rst SHALL immediately clear the pointers, count and wr_en_q, and set drop_err=0, empty=1, full=0, almost_full=0, rd_valid=0 and lk_hit=0.
REQ-040 Array contents need not be reset, and reset mid-operation SHALL discard all queued stores.
REQ-041 Because wr_en_q resets to 0, wr_en held high through reset release SHALL count as one edge on the first clock after release.

Verification
REQ-042 Bench scenarios are as follows:
- Scenario 1: DEPTH=4, EDGE_WRITE=1, rd_ready=0; pulse wr_en 4x with addr 0x10..0x13 and data 0xA0..0xA3 -> count=4, full=1, almost_full=1; a 5th pulse leaves count=4 and sets drop_err=1.
- Scenario 2: from full, raise rd_ready -> rd_valid=1 with rd_addr=0x10, rd_data=0xA0, then 0x11/0xA1 and so on in order; after 4 cycles empty=1 and rd_valid=0.
- Scenario 3: full queue, push edge (addr 0x20, data 0xB0) together with rd_ready=1 -> count stays 4, drop_err unchanged, and 0xB0 is popped last.
- Scenario 4: push (0x30,0x01), (0x31,0x02), (0x30,0x03); lk_addr=0x30 -> lk_hit=1, lk_data=0x03; lk_addr=0x99 -> lk_hit=0.
- Scenario 5: EDGE_WRITE=0, wr_en held high 3 cycles with rd_ready=0 -> count=3; with EDGE_WRITE=1 the same stimulus gives count=1.
- Scenario 6: rst asserted between clock edges while count=2 -> outputs reach reset values before the next edge; a following lookup of a stale address -> lk_hit=0.
